conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL take parameters from renkon_pkg: DWIDTH, default 16, data width; FSIZE, default 5, kernel side (3 or 5); FACCUM, default 10, feature-memory address width; LWIDTH, default 10, count width; CONV_LAT, default 4, datapath latency from mem_feat_addr to mem_feat_addr_d.
REQ-002 SHALL have the following ports:
clk  in  1  sole clock, rising edge;
xrst  in  1  asynchronous active-low reset;
req  in  1  start one output-channel job;
n_in  in  LWIDTH  number of input channels (0 is treated as 1);
out_size  in  LWIDTH  output map side length;
ack  out  1  one-cycle pulse when the job completes;
busy  out  1  high from the cycle after req is accepted until ack;
wreg_we  out  1  weight-register shift enable;
w_addr  out  LWIDTH+5  weight memory read address;
pix_en  out  1  request for the next window from the line buffer;
mem_feat_we  out  1  write enable for the accumulation memory;
mem_feat_rst  out  1  first-channel flag, meaning accumulate from zero;
mem_feat_addr  out  FACCUM  read address for the partial sum;
mem_feat_addr_d  out  FACCUM  write address, equal to mem_feat_addr delayed CONV_LAT cycles;
out_en  out  1  last-channel flag, meaning results are streamed out.

Function
REQ-003 SHALL implement states IDLE, WLOAD, CONV, DRAIN, DONE.
REQ-004 SHALL accept req only in IDLE: latch n_in (0→1) and out_size, clear counters, go to WLOAD; req SHALL be ignored in all other states.
REQ-005 WLOAD SHALL assert wreg_we for exactly FSIZE**2 consecutive cycles with w_addr incrementing by 1 from ch*FSIZE**2, then go to CONV.
REQ-006 CONV SHALL assert pix_en and advance mem_feat_addr 0..out_size**2-1, one address per cycle, for out_size**2 cycles, then go to DRAIN.
REQ-007 DRAIN SHALL last CONV_LAT cycles; at its end the channel counter increments, and the FSM goes to WLOAD if channels remain, otherwise to DONE.
REQ-008 mem_feat_we SHALL equal pix_en delayed CONV_LAT cycles; mem_feat_addr_d SHALL equal mem_feat_addr delayed CONV_LAT cycles, in the same pipeline.
REQ-009 mem_feat_rst SHALL be high, aligned with mem_feat_we, for every write of channel 0; out_en SHALL be high, aligned with mem_feat_we, for every write of channel n_in-1.
REQ-010 When n_in=1, mem_feat_rst and out_en SHALL both be high for the same writes.
REQ-011 DONE SHALL pulse ack for one cycle, drop busy in the same cycle and return to IDLE; a req in that DONE cycle SHALL be ignored.
REQ-012 mem_feat_addr SHALL wrap to 0 at channel change and SHALL never exceed out_size**2-1; out_size=0 SHALL skip CONV (zero pixels) while still sequencing WLOAD and DRAIN.
REQ-013 Counters SHALL be sized so that out_size**2 fits in FACCUM and n_in*FSIZE**2 fits in w_addr; larger configurations are unsupported.
REQ-014 The total job length SHALL be n_in*(FSIZE**2 + out_size**2 + CONV_LAT) + 2 cycles, measured from the req cycle to the ack cycle.

Reset
REQ-015 While xrst=0, the FSM SHALL be in IDLE and every output, counter and delay stage SHALL be 0, asynchronously.
REQ-016 Reset asserted mid-job SHALL abort the job with no ack and no further mem_feat_we, and a req after release SHALL start a fresh job.

Structure
REQ-017 The state enum, CONV_LAT, LWIDTH and FSIZE SHALL reside in renkon_pkg.
REQ-018 The CONV_LAT-deep delay of {pix_en, addr, first, last} SHALL be a sub-module named ctrl_delay, parameterized on width and depth.

Verification
REQ-019 FSIZE=3, n_in=1, out_size=2, CONV_LAT=4 -> 9 wreg_we cycles with w_addr 0..8, then 4 pix_en cycles with addr 0,1,2,3; addr_d shows 0..3 four cycles later with mem_feat_rst=out_en=1; ack at cycle 19.
REQ-020 n_in=3, out_size=2 -> rst is high only for channel-0 writes and out_en only for channel-2 writes; w_addr starts at 0, 9 and 18; exactly 12 writes in total.
REQ-021 req held high throughout, and also during the DONE cycle -> exactly one job and one ack, and no restart until a later IDLE req.
REQ-022 n_in=0 -> the job behaves identically to n_in=1.
REQ-023 xrst pulsed during the CONV of channel 1 -> all outputs 0 immediately, no ack; the next req produces a full correct job.
REQ-024 out_size=0, n_in=2 -> no pix_en and no mem_feat_we; ack after 2*(9+4)+2 cycles.

Source files
------------

// File: rtl/renkon_pkg.sv
// Shared constants and FSM encoding for the renkon convolution controller.
package renkon_pkg;
  localparam int DWIDTH   = 16;
  localparam int FSIZE    = 5;
  localparam int FACCUM   = 10;
  localparam int LWIDTH   = 10;
  localparam int CONV_LAT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    CONV  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/conv_ctrl_if.sv
// Job request/ack and memory-control bundle of the convolution controller.
interface conv_ctrl_if #(
  parameter int LWIDTH = renkon_pkg::LWIDTH,
  parameter int FACCUM = renkon_pkg::FACCUM
);
  // req is sampled only while the controller is idle; busy covers the job
  // from the cycle after acceptance, and a single-cycle ack (busy low) ends it.
  logic              req;
  logic [LWIDTH-1:0] n_in;
  logic [LWIDTH-1:0] out_size;
  logic              ack;
  logic              busy;
  logic              wreg_we;
  logic [LWIDTH+4:0] w_addr;
  logic              pix_en;
  logic              mem_feat_we;
  logic              mem_feat_rst;
  logic [FACCUM-1:0] mem_feat_addr;
  logic [FACCUM-1:0] mem_feat_addr_d;
  logic              out_en;
  renkon_pkg::state_t dbg_state;

  modport master (
    output req, n_in, out_size,
    input  ack, busy, wreg_we, w_addr, pix_en, mem_feat_we, mem_feat_rst,
           mem_feat_addr, mem_feat_addr_d, out_en, dbg_state
  );

  modport slave (
    input  req, n_in, out_size,
    output ack, busy, wreg_we, w_addr, pix_en, mem_feat_we, mem_feat_rst,
           mem_feat_addr, mem_feat_addr_d, out_en, dbg_state
  );
endinterface

// File: rtl/ctrl_delay.sv
// Fixed-depth shift pipeline that aligns control bits with the datapath latency.
module ctrl_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for one output channel: per input channel, load weights, sweep the
// output map, then drain the datapath before moving to the next channel.
module conv_ctrl #(
  parameter int FSIZE    = renkon_pkg::FSIZE,
  parameter int FACCUM   = renkon_pkg::FACCUM,
  parameter int LWIDTH   = renkon_pkg::LWIDTH,
  parameter int CONV_LAT = renkon_pkg::CONV_LAT
) (
  input logic        clk,
  input logic        xrst,
  conv_ctrl_if.slave bus
);
  import renkon_pkg::state_t;
  import renkon_pkg::IDLE;
  import renkon_pkg::WLOAD;
  import renkon_pkg::CONV;
  import renkon_pkg::DRAIN;
  import renkon_pkg::DONE;

  localparam int KW  = (FSIZE * FSIZE > 1) ? $clog2(FSIZE * FSIZE) : 1;
  localparam int DW  = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam int PDW = FACCUM + 3;
  localparam logic [KW-1:0] KLAST = KW'(FSIZE * FSIZE - 1);
  localparam logic [DW-1:0] DLAST = DW'(CONV_LAT - 1);

  state_t            state, state_n;
  logic [LWIDTH-1:0] n_lat, ch, ch_next;
  logic [FACCUM-1:0] npix, npix_in, addr;
  logic [KW-1:0]     kcnt;
  logic [DW-1:0]     dcnt;
  logic [LWIDTH+4:0] w_addr;
  logic              wreg_we, pix_en, ack, busy;
  logic              first_ch, last_ch;
  logic [PDW-1:0]    pipe_in, pipe_out;

  assign ch_next  = ch + 1'b1;
  assign npix_in  = FACCUM'(bus.out_size * bus.out_size);
  assign first_ch = (ch == '0);
  assign last_ch  = (ch_next == n_lat);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    wreg_we = 1'b0;
    pix_en  = 1'b0;
    ack     = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE: if (bus.req) state_n = WLOAD;
      WLOAD: begin
        busy    = 1'b1;
        wreg_we = 1'b1;
        // An empty output map skips the sweep but still drains.
        if (kcnt == KLAST) state_n = (npix == '0) ? DRAIN : CONV;
      end
      CONV: begin
        busy   = 1'b1;
        pix_en = 1'b1;
        if (addr == npix - 1'b1) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == DLAST) state_n = last_ch ? DONE : WLOAD;
      end
      DONE: begin
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // w_addr runs continuously across channels, so each channel starts at ch*FSIZE**2.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      n_lat  <= '0;
      npix   <= '0;
      ch     <= '0;
      kcnt   <= '0;
      dcnt   <= '0;
      addr   <= '0;
      w_addr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          n_lat  <= (bus.n_in == '0) ? LWIDTH'(1) : bus.n_in;
          npix   <= npix_in;
          ch     <= '0;
          kcnt   <= '0;
          dcnt   <= '0;
          addr   <= '0;
          w_addr <= '0;
        end
        WLOAD: begin
          w_addr <= w_addr + 1'b1;
          kcnt   <= (kcnt == KLAST) ? '0 : kcnt + 1'b1;
        end
        CONV: addr <= (addr == npix - 1'b1) ? '0 : addr + 1'b1;
        DRAIN: begin
          dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
          if (dcnt == DLAST) ch <= ch_next;
        end
        default: ;
      endcase
    end
  end

  assign pipe_in = {pix_en, addr, pix_en & first_ch, pix_en & last_ch};

  ctrl_delay #(.WIDTH(PDW), .DEPTH(CONV_LAT)) u_delay (
    .clk  (clk),
    .xrst (xrst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign bus.mem_feat_we     = pipe_out[PDW-1];
  assign bus.mem_feat_addr_d = pipe_out[PDW-2:2];
  assign bus.mem_feat_rst    = pipe_out[1];
  assign bus.out_en          = pipe_out[0];
  assign bus.ack             = ack;
  assign bus.busy            = busy;
  assign bus.wreg_we         = wreg_we;
  assign bus.w_addr          = w_addr;
  assign bus.pix_en          = pix_en;
  assign bus.mem_feat_addr   = addr;
  assign bus.dbg_state       = state;
endmodule
